oam_dma_ctrl: RTL and testbench
===============================

# oam_dma_ctrl

Sprite DMA engine on the CPU-side bus, downstream of the CPU core and WRAM and upstream of the PPU OAM port. It snoops CPU writes to $4014, drops the CPU ready line, and copies the 256-byte WRAM page $XX00–$XXFF into PPU OAM one byte per two CPU cycles. It then releases the CPU. It is the source of the top-level `oam_dma` and `oam_addr` signals and the DMA contribution to `rdy`.

## Interface
- Parameters: none; constants come from the package.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_ce` in 1: one-clk strobe marking each CPU cycle; all DMA steps advance only on clocks with `cpu_ce`=1.
- `cpu_addr` in 16: CPU address bus.
- `cpu_data` in 8: CPU write data.
- `cpu_r_nw` in 1: 1=read, 0=write.
- `oam_addr_start` in 8: PPU OAMADDR value; sampled at trigger.
- `wram_data_in` in 8: WRAM read data; valid on the `cpu_ce` following address presentation.
- `dma_addr` out 16: WRAM address during DMA; 16'h0000 when idle.
- `dma_rd` out 1: high while `dma_addr` is valid.
- `oam_dma` out 1: high from trigger to completion.
- `dma_rdy` out 1: 1 = CPU may run, 0 = CPU halted.
- `oam_addr` out 8: OAM write address.
- `oam_data` out 8: OAM write data.
- `oam_we` out 1: OAM write strobe, one clk wide.

## Operation
- Parity bit `par` toggles on every `cpu_ce` and resets to 0. It tags each CPU cycle as even (`par`=0) or odd.
- Trigger: on a `cpu_ce` clock in IDLE with `cpu_addr`=16'h4014 and `cpu_r_nw`=0:
  - latch `page` from `cpu_data` and `oaddr` from `oam_addr_start`;
  - clear `idx` to 0;
  - go to HALT.
- States: IDLE, HALT, ALIGN, READ, WRITE. Every transition except the trigger happens only on `cpu_ce`.
  - HALT: one dummy cycle, which lets the CPU finish its write. If the next cycle is even, go to READ; otherwise go to ALIGN.
  - ALIGN: one dummy cycle, then READ. READ therefore always occurs on an even cycle.
  - READ: drive `dma_addr`={`page`,`idx`} and `dma_rd`=1, then go to WRITE.
  - WRITE:
    - capture `wram_data_in` into `oam_data` and present `oam_addr`=`oaddr`;
    - pulse `oam_we` for that single clk;
    - increment `idx` and `oaddr` mod 256;
    - if `idx` was 255, go to IDLE; otherwise go to READ.
- Any $4014 write while not in IDLE is ignored; the CPU is halted, so this is a safety case only.
- `oam_dma`=1 in every state except IDLE. `dma_rdy`=~`oam_dma`.
- Width rules: `idx` and `oaddr` are 8-bit and wrap naturally. Completion is detected by `idx`==8'hFF in WRITE, not by overflow.

## Timing
- Reset values:
  - state IDLE, `par`=0;
  - `dma_rdy`=1, `oam_dma`=0, `dma_rd`=0, `oam_we`=0;
  - `dma_addr`=0, `oam_addr`=0, `oam_data`=0;
  - `page`=0, `idx`=0.
- Reset asserted mid-transfer aborts immediately and asynchronously. OAM keeps any bytes already written.
- `dma_rdy` falls on the clk edge that samples the trigger `cpu_ce`, and rises on the edge that samples the final WRITE `cpu_ce`.
- Halted CPU cycles: 513 if the trigger cycle is odd (HALT even, no ALIGN), 514 if the trigger cycle is even.
- Each byte costs 2 CPU cycles, READ then WRITE. Byte k is written on the WRITE following the READ of address {`page`,k}.
- `oam_we` is high exactly 256 clks per transfer, never adjacent, and only on WRITE `cpu_ce` clocks.
- When `cpu_ce` is low, all outputs hold.

## Structure
- Shared package `nes_pkg` holds:
  - `DMA_TRIG_ADDR`=16'h4014;
  - `dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE);
  - `OAM_SIZE`=256.
- Single flat module; no sub-module is warranted. Parity toggle and counters live inline.
- The top level ANDs `dma_rdy` with any other ready sources and ORs `dma_addr` onto the WRAM address mux when `dma_rd`=1.

## Test plan
- Trigger with $4014←8'h02 on an odd cycle, WRAM $0200+k=k^8'h5A, `oam_addr_start`=0 -> 256 `oam_we` pulses with `oam_addr`=k and `oam_data`=k^8'h5A; `dma_rdy` low for exactly 513 CPU cycles.
- Same trigger on an even cycle -> one ALIGN cycle; `dma_rdy` low for 514 CPU cycles; first READ on an even cycle.
- `oam_addr_start`=8'hF0 -> first write to OAM 8'hF0; byte 16 written to 8'h00 (wraparound); last write to 8'hEF.
- Second $4014 write injected mid-transfer, plus `cpu_r_nw`=1 accesses to $4014 while idle -> no restart, no extra writes; reads never trigger.
- Assert `reset` at byte 100 -> outputs return to reset values within the same clk; a new trigger afterwards runs a full clean 256-byte transfer.
- `cpu_ce` asserted once per 12 clks, randomly gapped -> identical OAM contents and cycle counts to the first case.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES-side constants and types used by the bus-side controllers.
package nes_pkg;

  // CPU write to this address starts a sprite DMA.
  localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;

  // Bytes copied per transfer (one WRAM page into the whole of OAM).
  localparam int          OAM_SIZE      = 256;

  // Index of the last byte in a transfer.
  localparam logic [7:0]  DMA_LAST_IDX  = 8'(OAM_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: snoops CPU writes to $4014, halts the CPU and copies
// the selected WRAM page into PPU OAM, one byte per two CPU cycles.
module oam_dma_ctrl
  import nes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_r_nw,
  input  logic [7:0]  oam_addr_start,
  input  logic [7:0]  wram_data_in,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic        oam_dma,
  output logic        dma_rdy,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_we
);

  dma_state_t  state, state_d;
  logic        par;
  logic [7:0]  page, page_d;
  logic [7:0]  idx, idx_d;
  logic [7:0]  oaddr, oaddr_d;
  logic [15:0] dma_addr_d;
  logic        dma_rd_d;
  logic [7:0]  oam_addr_d;
  logic [7:0]  oam_data_d;
  logic        oam_we_d;

  // Register state, parity, counters and all outputs; reset aborts at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      par      <= 1'b0;
      page     <= 8'h00;
      idx      <= 8'h00;
      oaddr    <= 8'h00;
      dma_addr <= 16'h0000;
      dma_rd   <= 1'b0;
      oam_addr <= 8'h00;
      oam_data <= 8'h00;
      oam_we   <= 1'b0;
    end else begin
      state    <= state_d;
      if (cpu_ce) par <= ~par;
      page     <= page_d;
      idx      <= idx_d;
      oaddr    <= oaddr_d;
      dma_addr <= dma_addr_d;
      dma_rd   <= dma_rd_d;
      oam_addr <= oam_addr_d;
      oam_data <= oam_data_d;
      oam_we   <= oam_we_d;
    end
  end

  // Next-state and next-output logic; everything advances only on cpu_ce.
  // A cpu_ce clock is "even" when par is 0 on it. READ is always entered on
  // an even cpu_ce so the WRAM fetch lines up with the CPU's read slot.
  always_comb begin
    // NOTE: every signal gets a default (hold, or 0 for the strobe) before
    // the case statement, so no path leaves one unassigned and no latch forms.
    state_d    = state;
    page_d     = page;
    idx_d      = idx;
    oaddr_d    = oaddr;
    dma_addr_d = dma_addr;
    dma_rd_d   = dma_rd;
    oam_addr_d = oam_addr;
    oam_data_d = oam_data;
    oam_we_d   = 1'b0;

    if (cpu_ce) begin
      unique case (state)
        IDLE: begin
          if (cpu_addr == DMA_TRIG_ADDR && !cpu_r_nw) begin
            page_d  = cpu_data;
            oaddr_d = oam_addr_start;
            idx_d   = 8'h00;
            state_d = HALT;
          end
        end

        // Dummy cycle so the CPU can finish its $4014 write.
        HALT: begin
          if (!par) begin
            state_d    = READ;
            dma_addr_d = {page, idx};
            dma_rd_d   = 1'b1;
          end else begin
            state_d    = ALIGN;
          end
        end

        // Extra dummy cycle that puts READ back on an even cpu_ce.
        ALIGN: begin
          state_d    = READ;
          dma_addr_d = {page, idx};
          dma_rd_d   = 1'b1;
        end

        // WRAM sees the address this cycle; its data arrives for WRITE.
        READ: begin
          state_d    = WRITE;
          dma_addr_d = 16'h0000;
          dma_rd_d   = 1'b0;
        end

        WRITE: begin
          oam_data_d = wram_data_in;
          oam_addr_d = oaddr;
          oam_we_d   = 1'b1;
          idx_d      = idx + 8'd1;
          oaddr_d    = oaddr + 8'd1;
          if (idx == DMA_LAST_IDX) begin
            state_d = IDLE;
          end else begin
            state_d    = READ;
            dma_addr_d = {page, idx + 8'd1};
            dma_rd_d   = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Busy whenever a transfer is in flight; the CPU runs only when idle.
  always_comb begin
    oam_dma = (state != IDLE);
    dma_rdy = ~oam_dma;
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: a table of transfer scenarios plus
// hand-written reset/idle sequences, checked against a WRAM/OAM model.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_r_nw;
  logic [7:0]  oam_addr_start;
  logic [7:0]  wram_data_in;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic        oam_dma;
  logic        dma_rdy;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;

  oam_dma_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_ce         (cpu_ce),
    .cpu_addr       (cpu_addr),
    .cpu_data       (cpu_data),
    .cpu_r_nw       (cpu_r_nw),
    .oam_addr_start (oam_addr_start),
    .wram_data_in   (wram_data_in),
    .dma_addr       (dma_addr),
    .dma_rd         (dma_rd),
    .oam_dma        (oam_dma),
    .dma_rdy        (dma_rdy),
    .oam_addr       (oam_addr),
    .oam_data       (oam_data),
    .oam_we         (oam_we)
  );

  always #5 clk = ~clk;

  // One transfer scenario and the values it must produce.
  typedef struct {
    string      name;
    bit         odd;        // trigger on an odd CPU cycle
    logic [7:0] page;       // page 2 uses the k^5A pattern, others random
    logic [7:0] start;      // OAMADDR at trigger
    bit         gapped;     // cpu_ce randomly once per 1..12 clks
    bit         inject;     // second $4014 write mid-transfer
    int         abort_at;   // byte count at which reset is asserted, -1 none
    logic [7:0] exp_first;  // first OAM address written
    logic [7:0] exp_last;   // last OAM address written
  } vec_t;

  int         vectors;
  int         miscompares;

  // Reference model state.
  logic [7:0] page_mem [256];
  logic [7:0] oam_m    [256];
  logic [7:0] ref_oam  [256];
  logic [7:0] cur_page;
  logic [7:0] exp_oaddr;
  logic [7:0] first_we_addr;
  logic [7:0] last_we_addr;
  int         ce_count;
  int         halted;
  int         we_count;
  int         exp_k;
  int         rd_k;
  int         bad_we;
  int         adj_we;
  bit         prev_we;
  bit         gapped_mode;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] rd_mem(input logic [15:0] a);
    if (a[15:8] == cur_page) return page_mem[a[7:0]];
    return 8'hEE;
  endfunction

  // One clk; outputs observed 1 time unit after the rising edge.
  task automatic step(input bit ce);
    bit          pre_rd;
    bit          pre_rdy;
    logic [15:0] pre_addr;
    int          edge_par;
    cpu_ce   = ce;
    pre_rd   = dma_rd;
    pre_addr = dma_addr;
    pre_rdy  = dma_rdy;
    edge_par = ce_count % 2;
    @(posedge clk);
    #1;
    if (ce) begin
      ce_count++;
      if (!pre_rdy) halted++;
      // WRAM answers on the cpu_ce after it sees the address.
      if (pre_rd) wram_data_in = rd_mem(pre_addr);
    end
    if (dma_rd && !pre_rd) begin
      check("rd_addr", {16'h0, dma_addr}, {16'h0, cur_page, 8'(rd_k)});
      check("rd_even", edge_par, 0);
      rd_k++;
    end
    if (oam_we) begin
      if (!ce) bad_we++;
      if (prev_we) adj_we++;
      we_count++;
      if (we_count == 1) first_we_addr = oam_addr;
      last_we_addr = oam_addr;
      check("oam_addr", {24'h0, oam_addr}, {24'h0, exp_oaddr});
      check("oam_data", {24'h0, oam_data}, {24'h0, page_mem[exp_k % 256]});
      oam_m[oam_addr] = oam_data;
      exp_k++;
      exp_oaddr++;
    end
    prev_we = oam_we;
  endtask

  // One CPU cycle: optional random idle clks, then a cpu_ce clock.
  task automatic cpu_cycle();
    if (gapped_mode) repeat ($urandom_range(0, 11)) step(1'b0);
    step(1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},      {31'h0, dma_rdy}, 32'h1);
    check({tag, "_oam_dma"},  {31'h0, oam_dma}, 32'h0);
    check({tag, "_dma_rd"},   {31'h0, dma_rd},  32'h0);
    check({tag, "_oam_we"},   {31'h0, oam_we},  32'h0);
    check({tag, "_dma_addr"}, {16'h0, dma_addr}, 32'h0);
    check({tag, "_oam_addr"}, {24'h0, oam_addr}, 32'h0);
    check({tag, "_oam_data"}, {24'h0, oam_data}, 32'h0);
  endtask

  task automatic run_transfer(input vec_t v);
    int trig_par;
    int cyc;
    int diffs;
    gapped_mode = v.gapped;
    cur_page    = v.page;
    for (int k = 0; k < 256; k++)
      page_mem[k] = (v.page == 8'h02) ? (8'(k) ^ 8'h5A) : 8'($urandom);

    cpu_addr = 16'h0000;
    cpu_r_nw = 1'b1;
    if ((ce_count % 2) != int'(v.odd)) cpu_cycle();

    halted = 0; we_count = 0; exp_k = 0; rd_k = 0; bad_we = 0; adj_we = 0;
    exp_oaddr = v.start;

    cpu_addr       = 16'h4014;
    cpu_r_nw       = 1'b0;
    cpu_data       = v.page;
    oam_addr_start = v.start;
    trig_par       = ce_count % 2;
    cpu_cycle();
    cpu_addr       = 16'h0000;
    cpu_r_nw       = 1'b1;
    oam_addr_start = 8'hA5;
    check({v.name, "_busy"}, {30'h0, oam_dma, dma_rdy}, 32'h2);

    cyc = 0;
    while (!dma_rdy && cyc < 1200) begin
      if (v.inject && cyc == 50) begin
        cpu_addr = 16'h4014; cpu_r_nw = 1'b0; cpu_data = 8'h77; oam_addr_start = 8'h33;
      end
      cpu_cycle();
      cpu_addr = 16'h0000; cpu_r_nw = 1'b1;
      cyc++;
      if (v.abort_at >= 0 && exp_k == v.abort_at) begin
        #2 reset = 1'b1;
        #1 check_reset_outputs({v.name, "_abort"});
        check({v.name, "_abort_bytes"}, exp_k, 32'(v.abort_at));
        @(negedge clk);
        reset        = 1'b0;
        ce_count     = 0;
        wram_data_in = 8'h00;
        prev_we      = 1'b0;
        return;
      end
    end
    check({v.name, "_timeout"}, {31'h0, dma_rdy}, 32'h1);

    // Halted cycles: one HALT, one ALIGN if the trigger cycle was even,
    // then a READ and a WRITE per byte.
    check({v.name, "_halted"}, halted, 1 + (trig_par == 0 ? 1 : 0) + 2 * 256);
    check({v.name, "_we_count"}, we_count, 256);
    check({v.name, "_we_bad"}, bad_we + adj_we, 0);
    check({v.name, "_first_addr"}, {24'h0, first_we_addr}, {24'h0, v.exp_first});
    check({v.name, "_last_addr"},  {24'h0, last_we_addr},  {24'h0, v.exp_last});

    diffs = 0;
    for (int k = 0; k < 256; k++)
      if (oam_m[8'(k) + v.start] !== page_mem[k]) diffs++;
    check({v.name, "_oam_contents"}, diffs, 0);

    // Idle reads of $4014 must not start anything.
    cpu_addr = 16'h4014;
    cpu_r_nw = 1'b1;
    repeat (4) cpu_cycle();
    cpu_addr = 16'h0000;
    check({v.name, "_idle_after"}, {31'h0, oam_dma}, 32'h0);
    check({v.name, "_no_extra_we"}, we_count, 256);
  endtask

  vec_t vecs [7];

  initial begin
    int diffs;
    vecs[0] = '{"odd_p02",    1'b1, 8'h02, 8'h00, 1'b0, 1'b0,  -1, 8'h00, 8'hFF};
    vecs[1] = '{"even_p02",   1'b0, 8'h02, 8'h00, 1'b0, 1'b0,  -1, 8'h00, 8'hFF};
    vecs[2] = '{"wrap_f0",    1'b1, 8'h03, 8'hF0, 1'b0, 1'b0,  -1, 8'hF0, 8'hEF};
    vecs[3] = '{"inject",     1'b0, 8'h05, 8'h10, 1'b0, 1'b1,  -1, 8'h10, 8'h0F};
    vecs[4] = '{"abort",      1'b1, 8'h06, 8'h00, 1'b0, 1'b0, 100, 8'h00, 8'hFF};
    vecs[5] = '{"after_rst",  1'b0, 8'h07, 8'h80, 1'b0, 1'b0,  -1, 8'h80, 8'h7F};
    vecs[6] = '{"gapped_p02", 1'b1, 8'h02, 8'h00, 1'b1, 1'b0,  -1, 8'h00, 8'hFF};

    vectors = 0; miscompares = 0;
    ce_count = 0; halted = 0; we_count = 0; exp_k = 0; rd_k = 0;
    bad_we = 0; adj_we = 0; prev_we = 1'b0; gapped_mode = 1'b0;
    cur_page = 8'h00; exp_oaddr = 8'h00; first_we_addr = 8'h00; last_we_addr = 8'h00;
    for (int k = 0; k < 256; k++) begin
      page_mem[k] = 8'h00; oam_m[k] = 8'h00; ref_oam[k] = 8'h00;
    end

    reset = 1'b1; cpu_ce = 1'b0; cpu_addr = 16'h0000; cpu_data = 8'h00;
    cpu_r_nw = 1'b1; oam_addr_start = 8'h00; wram_data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // Reads of $4014 and writes to a neighbouring register never trigger.
    cpu_addr = 16'h4014; cpu_r_nw = 1'b1; cpu_data = 8'h02;
    repeat (5) cpu_cycle();
    cpu_addr = 16'h4015; cpu_r_nw = 1'b0;
    repeat (2) cpu_cycle();
    cpu_addr = 16'h0000; cpu_r_nw = 1'b1;
    check("idle_reads_dma", {31'h0, oam_dma}, 32'h0);
    check("idle_reads_we", we_count, 0);

    for (int i = 0; i < 7; i++) begin
      run_transfer(vecs[i]);
      if (i == 0)
        for (int k = 0; k < 256; k++) ref_oam[k] = oam_m[k];
    end

    // Gapped cpu_ce must leave OAM exactly as the first transfer did.
    diffs = 0;
    for (int k = 0; k < 256; k++)
      if (oam_m[k] !== ref_oam[k]) diffs++;
    check("gapped_vs_first", diffs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
